// File: rtl/aes_decrypt_pipe_core.sv
// Iterative AES-128 inverse cipher with a once-per-key round-key cache,
// ECB/CBC chaining and valid/ready handshakes; RPC rounds are applied per cycle.
module aes_decrypt_pipe_core #(
    parameter int RPC    = 1,
    parameter bit CBC_EN = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         key_load,
    input  logic [127:0] key,
    output logic         key_ready,
    input  logic         cbc_mode,
    input  logic         iv_load,
    input  logic [127:0] iv,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data
);

    if (RPC != 1 && RPC != 2 && RPC != 5 && RPC != 10) begin : g_bad_rpc
        $fatal(1, "aes_decrypt_pipe_core: RPC must be 1, 2, 5 or 10");
    end

    typedef enum logic [2:0] {KEY_WAIT, KEY_EXPAND, IDLE, ROUND, OUTPUT} fsm_t;

    fsm_t         fsm;
    logic [3:0]   round_cnt;
    logic [3:0]   kcnt;
    logic [3:0]   kidx;
    logic [127:0] rk [0:10];
    logic [127:0] blk_p0;
    logic [127:0] ct_p0;
    logic         mode_p0;
    logic [127:0] chain;
    logic [127:0] blk_nxt;
    logic [127:0] kexp_nxt;
    logic [3:0]   r;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Multiplicative inverse as a^254 by repeated squaring; maps 0 to 0.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] p;
        logic [7:0] s;
        p = 8'h01;
        s = a;
        for (int i = 1; i < 8; i++) begin
            s = gmul(s, s);
            p = gmul(p, s);
        end
        return p;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] b;
        b = gf_inv(a);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] s);
        logic [7:0] b;
        b = {s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05;
        return gf_inv(b);
    endfunction

    function automatic logic [127:0] inv_shift_rows(input logic [127:0] x);
        logic [127:0] y;
        y = '0;
        for (int c = 0; c < 4; c++) begin
            for (int rr = 0; rr < 4; rr++) begin
                y[127-8*(rr+4*c) -: 8] = x[127-8*(rr+4*((c+4-rr)%4)) -: 8];
            end
        end
        return y;
    endfunction

    function automatic logic [127:0] inv_sub_bytes(input logic [127:0] x);
        logic [127:0] y;
        y = '0;
        for (int i = 0; i < 16; i++) begin
            y[127-8*i -: 8] = inv_sbox(x[127-8*i -: 8]);
        end
        return y;
    endfunction

    function automatic logic [127:0] inv_mix_columns(input logic [127:0] x);
        logic [127:0] y;
        logic [7:0]   a0, a1, a2, a3;
        y = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = x[127-32*c -: 8];
            a1 = x[119-32*c -: 8];
            a2 = x[111-32*c -: 8];
            a3 = x[103-32*c -: 8];
            y[127-32*c -: 8] = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
            y[119-32*c -: 8] = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
            y[111-32*c -: 8] = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
            y[103-32*c -: 8] = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
        end
        return y;
    endfunction

    function automatic logic [127:0] inv_round(input logic [127:0] x, input logic [127:0] k,
                                               input logic last);
        logic [127:0] t;
        t = inv_sub_bytes(inv_shift_rows(x)) ^ k;
        return last ? t : inv_mix_columns(t);
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] i);
        case (i)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [127:0] key_step(input logic [127:0] w, input logic [7:0] rc);
        logic [31:0] t, n0, n1, n2, n3;
        t  = {sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0]), sbox(w[31:24])} ^ {rc, 24'h000000};
        n0 = w[127:96] ^ t;
        n1 = w[95:64] ^ n0;
        n2 = w[63:32] ^ n1;
        n3 = w[31:0] ^ n2;
        return {n0, n1, n2, n3};
    endfunction

    assign in_ready = (fsm == IDLE);
    assign kidx     = (kcnt == 4'd0) ? 4'd0 : kcnt - 4'd1;
    assign kexp_nxt = key_step(rk[kidx], rcon(kcnt));

    // Round stage: RPC inverse rounds chained combinationally, descending round index.
    always_comb begin
        blk_nxt = blk_p0;
        r       = 4'd0;
        for (int j = 0; j < RPC; j++) begin
            r       = (round_cnt >= 4'(j)) ? round_cnt - 4'(j) : 4'd0;
            blk_nxt = inv_round(blk_nxt, rk[r], r == 4'd0);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm       <= KEY_WAIT;
            key_ready <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            chain     <= '0;
            round_cnt <= 4'd0;
            kcnt      <= 4'd0;
            mode_p0   <= 1'b0;
        end else begin
            if (key_load) begin
                fsm       <= KEY_EXPAND;
                key_ready <= 1'b0;
                out_valid <= 1'b0;
                kcnt      <= 4'd1;
            end else begin
                case (fsm)
                    KEY_EXPAND: begin
                        if (kcnt == 4'd10) begin
                            key_ready <= 1'b1;
                            fsm       <= IDLE;
                        end else begin
                            kcnt <= kcnt + 4'd1;
                        end
                    end
                    IDLE: begin
                        if (in_valid) begin
                            round_cnt <= 4'd9;
                            mode_p0   <= cbc_mode & CBC_EN;
                            fsm       <= ROUND;
                        end
                    end
                    ROUND: begin
                        round_cnt <= round_cnt - 4'(RPC);
                        if (round_cnt == 4'(RPC - 1)) begin
                            out_data  <= blk_nxt ^ (mode_p0 ? chain : 128'd0);
                            out_valid <= 1'b1;
                            fsm       <= OUTPUT;
                        end
                    end
                    OUTPUT: begin
                        if (out_ready) begin
                            out_valid <= 1'b0;
                            if (mode_p0) chain <= ct_p0;
                            fsm <= IDLE;
                        end
                    end
                    default: ;
                endcase
            end
            // A software IV load overrides the chain update from a concurrent handshake.
            if (iv_load) chain <= iv;
        end
    end

    // Key cache and block state carry no reset; their contents are qualified by the FSM.
    always_ff @(posedge clk) begin
        if (key_load) begin
            rk[0] <= key;
        end else if (fsm == KEY_EXPAND) begin
            rk[kcnt] <= kexp_nxt;
        end
        if (!key_load && fsm == IDLE && in_valid) begin
            blk_p0 <= in_data ^ rk[10];
            ct_p0  <= in_data;
        end else if (fsm == ROUND) begin
            blk_p0 <= blk_nxt;
        end
    end

endmodule

// File: tb/tb_aes_decrypt_pipe_core.sv
// Scoreboard bench for aes_decrypt_pipe_core: four instances (RPC 1/2/5/10) share stimulus,
// instance 0 is checked in full, the others for latency and result on the first vector.
module tb_aes_decrypt_pipe_core;

    localparam int NDUT = 4;

    localparam logic [127:0] K1   = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] CT1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] PT1  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] K2   = 128'h33DE20E331BA5A525AB7C2495A767B5A;
    localparam logic [127:0] CT2  = 128'h67928dd5470d4a11f0ea4ae7d49b2dd4;
    localparam logic [127:0] PT2  = 128'hE6FEBF30133874EBCB49226CD36D0D4F;
    localparam logic [127:0] K3   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] IV   = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1   = 128'h7649abac8119b246cee98e9b12e9197d;
    localparam logic [127:0] C2   = 128'h5086cb9b507219ee95db113a917678b2;
    localparam logic [127:0] P1   = 128'h6bc1bee22e409f96e93d7e117393172a;
    localparam logic [127:0] P2   = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
    localparam logic [127:0] D_C1 = 128'h6bc0bce12a459991e134741a7f9e1925;
    localparam logic [127:0] D_C2 = 128'hd86421fb9f1a1eda505ee1375746972c;

    function automatic int rpc_of(input int g);
        case (g)
            0:       return 1;
            1:       return 2;
            2:       return 5;
            default: return 10;
        endcase
    endfunction

    logic              tb_clk = 1'b0;
    logic              rst, key_load, cbc_mode, iv_load, in_valid, out_ready;
    logic [127:0]      key, iv, in_data;
    logic [NDUT-1:0]   key_ready_v, in_ready_v, out_valid_v;
    logic [127:0]      out_data_v [NDUT];

    int                n_chk  = 0;
    int                n_fail = 0;
    int                cyc    = 0;
    logic [127:0]      sb [$];

    always #5 tb_clk = ~tb_clk;
    always @(posedge tb_clk) cyc <= cyc + 1;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        aes_decrypt_pipe_core #(.RPC(rpc_of(g)), .CBC_EN(1'b1)) u_dut (
            .clk       (tb_clk),
            .rst       (rst),
            .key_load  (key_load),
            .key       (key),
            .key_ready (key_ready_v[g]),
            .cbc_mode  (cbc_mode),
            .iv_load   (iv_load),
            .iv        (iv),
            .in_valid  (in_valid),
            .in_ready  (in_ready_v[g]),
            .in_data   (in_data),
            .out_valid (out_valid_v[g]),
            .out_ready (out_ready),
            .out_data  (out_data_v[g])
        );
    end

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Output monitor: every handshake on instance 0 must match the oldest scoreboard entry.
    always @(negedge tb_clk) begin
        if (!rst && out_valid_v[0] && out_ready) begin
            if (sb.size() == 0) begin
                chk("spurious_out_valid", 128'(out_valid_v[0]), 128'd0);
            end else begin
                chk("out_data", out_data_v[0], sb.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge tb_clk);
        #1;
    endtask

    task automatic load_key(input logic [127:0] k);
        key      = k;
        key_load = 1'b1;
        tick();
        key_load = 1'b0;
    endtask

    task automatic wait_key();
        bit ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (key_ready_v[0]) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        if (!ok) chk("tmo_key_ready", 128'(key_ready_v[0]), 128'd1);
    endtask

    task automatic send(input logic [127:0] ct, input logic [127:0] exp, input logic mode,
                        input bit push, output int acc);
        in_data  = ct;
        cbc_mode = mode;
        in_valid = 1'b1;
        acc      = -1;
        for (int i = 0; i < 200; i++) begin
            @(negedge tb_clk);
            if (in_ready_v[0]) begin
                if (push) sb.push_back(exp);
                tick();
                acc = cyc;
                break;
            end
        end
        in_valid = 1'b0;
        if (acc < 0) chk("tmo_in_ready", 128'(in_ready_v[0]), 128'd1);
    endtask

    task automatic wait_valid();
        bit ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge tb_clk);
            if (out_valid_v[0]) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("tmo_out_valid", 128'(out_valid_v[0]), 128'd1);
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge tb_clk);
        if (sb.size() != 0) chk("tmo_drain", 128'(sb.size()), 128'd0);
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int           acc, a1, a2, hs;
        int           lat [NDUT];
        logic [127:0] dat [NDUT];

        rst = 1'b1; key_load = 1'b0; key = '0; cbc_mode = 1'b0; iv_load = 1'b0;
        iv = '0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        repeat (3) tick();
        chk("rst_key_ready", 128'(key_ready_v), 128'd0);
        chk("rst_in_ready", 128'(in_ready_v), 128'd0);
        chk("rst_out_valid", 128'(out_valid_v), 128'd0);
        chk("rst_out_data", out_data_v[0], 128'd0);
        rst = 1'b0;
        tick();

        // FIPS-197 vector on all four RPC variants
        load_key(K1);
        for (int i = 1; i <= 10; i++) begin
            tick();
            if (i == 9) chk("kexp_busy", 128'(key_ready_v), 128'd0);
            if (i == 10) begin
                chk("kexp_done", 128'(key_ready_v), 128'hf);
                chk("kexp_in_ready", 128'(in_ready_v), 128'hf);
            end
        end
        for (int g = 0; g < NDUT; g++) begin
            lat[g] = 0;
            dat[g] = '0;
        end
        send(CT1, PT1, 1'b0, 1'b1, acc);
        for (int k = 1; k <= 15; k++) begin
            @(posedge tb_clk);
            @(negedge tb_clk);
            for (int g = 0; g < NDUT; g++) begin
                if (out_valid_v[g] && lat[g] == 0) begin
                    lat[g] = k;
                    dat[g] = out_data_v[g];
                end
            end
        end
        for (int g = 0; g < NDUT; g++) begin
            chk($sformatf("latency_rpc%0d", rpc_of(g)), 128'(lat[g]), 128'(10 / rpc_of(g)));
            chk($sformatf("data_rpc%0d", rpc_of(g)), dat[g], PT1);
        end
        tick();

        // Back-to-back blocks under one key
        load_key(K2);
        wait_key();
        send(CT2, PT2, 1'b0, 1'b1, a1);
        send(CT2, PT2, 1'b0, 1'b1, a2);
        chk("b2b_interval", 128'(a2 - a1), 128'd12);
        chk("b2b_key_ready", 128'(key_ready_v[0]), 128'd1);
        wait_drain();

        // CBC chain from IV
        load_key(K3);
        wait_key();
        iv = IV; iv_load = 1'b1;
        tick();
        iv_load = 1'b0;
        send(C1, P1, 1'b1, 1'b1, acc);
        send(C2, P2, 1'b1, 1'b1, acc);
        wait_drain();

        // Backpressure in OUTPUT
        out_ready = 1'b0;
        send(C1, D_C1, 1'b0, 1'b1, acc);
        wait_valid();
        in_data = C2; cbc_mode = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 7; i++) begin
            chk("bp_hold_data", out_data_v[0], D_C1);
            chk("bp_hold_valid", 128'(out_valid_v[0]), 128'd1);
            chk("bp_in_ready", 128'(in_ready_v[0]), 128'd0);
            @(negedge tb_clk);
        end
        tick();
        hs = cyc + 1;
        out_ready = 1'b1;
        send(C2, D_C2, 1'b0, 1'b1, acc);
        chk("bp_accept_after_hs", 128'(acc), 128'(hs + 1));
        wait_drain();

        // key_load mid-ROUND aborts the block
        send(C1, 128'd0, 1'b0, 1'b0, acc);
        repeat (3) tick();
        load_key(K1);
        in_data = CT1; cbc_mode = 1'b0; in_valid = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            tick();
            if (i < 10) begin
                chk("abort_key_ready", 128'(key_ready_v[0]), 128'd0);
                chk("abort_in_ready", 128'(in_ready_v[0]), 128'd0);
            end else begin
                chk("abort_rekey_done", 128'(key_ready_v[0]), 128'd1);
            end
        end
        send(CT1, PT1, 1'b0, 1'b1, acc);
        wait_drain();

        // key_load and in_valid on the same edge
        key = K1; key_load = 1'b1; in_data = CT1; in_valid = 1'b1;
        tick();
        key_load = 1'b0; in_valid = 1'b0;
        chk("same_edge_key_ready", 128'(key_ready_v[0]), 128'd0);
        chk("same_edge_in_ready", 128'(in_ready_v[0]), 128'd0);
        wait_key();

        // Asynchronous reset during OUTPUT
        out_ready = 1'b0;
        send(CT1, 128'd0, 1'b0, 1'b0, acc);
        wait_valid();
        #2 rst = 1'b1;
        #1;
        chk("arst_out_valid", 128'(out_valid_v), 128'd0);
        chk("arst_key_ready", 128'(key_ready_v), 128'd0);
        chk("arst_in_ready", 128'(in_ready_v), 128'd0);
        chk("arst_out_data", out_data_v[0], 128'd0);
        tick();
        rst = 1'b0;
        in_data = CT1; in_valid = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("post_rst_in_ready", 128'(in_ready_v[0]), 128'd0);
            chk("post_rst_out_valid", 128'(out_valid_v[0]), 128'd0);
        end
        in_valid = 1'b0;

        // iv_load on the CBC handshake edge wins; ECB leaves chain alone
        load_key(K3);
        wait_key();
        iv = IV; iv_load = 1'b1;
        tick();
        iv_load = 1'b0;
        out_ready = 1'b0;
        send(C1, P1, 1'b1, 1'b1, acc);
        wait_valid();
        tick();
        iv = IV; iv_load = 1'b1; out_ready = 1'b1;
        tick();
        iv_load = 1'b0;
        send(C1, P1, 1'b1, 1'b1, acc);
        send(C1, D_C1, 1'b0, 1'b1, acc);
        send(C2, P2, 1'b1, 1'b1, acc);
        wait_drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
